mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates the cache block's instruction-fetch and data channels onto a
// single-ported RAM. Data accesses take priority over fetches. A starvation
// counter limits how many data accesses in a row may complete while a fetch
// is waiting, so fetches always make progress. Each RAM access stays driven
// until the RAM reports ACCESS. On ERROR the arbiter backs off for one cycle
// and the request goes back through normal arbitration.
//
// Handshake: a requester raises its enable(s) with a stable address/data and
// keeps them stable while its wait output is high. The wait output is low for
// exactly the one cycle in which the access completes: iload/dload valid for
// reads, write done for writes. Dropping the enables while granted aborts the
// access without a wait pulse.
//
// Optional feature (macro MEM_ARBITER_STATS_EN): adds the igrant_cnt and
// dgrant_cnt completion counters (32 bits each, wrapping) and err_cnt
// (16 bits, saturating), which counts ERROR responses.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, iaddr          instruction read request and address
//   dREN, dWEN           data read/write request (write wins if both are set)
//   daddr, dstore        data address and write value
//   iwait, dwait         per-requester stall, low on the completion cycle
//   iload, dload         read data (ramload passthrough)
//   ramREN, ramWEN       RAM read/write enables
//   ramaddr, ramstore    RAM address and write data
//   ramload, ramstate    RAM read data and status (0 FREE,1 BUSY,2 ACCESS,3 ERROR)
//   igrant_cnt, dgrant_cnt, err_cnt   statistics (MEM_ARBITER_STATS_EN only)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int WORD_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]       igrant_cnt,
    output logic [31:0]       dgrant_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam int         STARVE_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DGNT    = 2'd1,
        S_IGNT    = 2'd2,
        S_BACKOFF = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [STARVE_W-1:0] r_starve;

    logic w_d_req;
    logic w_d_done;
    logic w_i_done;
    logic w_err;

    assign w_d_req  = dREN | dWEN;
    assign w_d_done = (r_state == S_DGNT) && w_d_req && (ramstate == RS_ACCESS);
    assign w_i_done = (r_state == S_IGNT) && iREN    && (ramstate == RS_ACCESS);
    // An ERROR only counts while the grant is still live; an aborted grant
    // has already released the RAM.
    assign w_err    = (((r_state == S_DGNT) && w_d_req) ||
                       ((r_state == S_IGNT) && iREN)) && (ramstate == RS_ERROR);

    assign iload = ramload;
    assign dload = ramload;

    // State register and starvation counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_starve <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_d_done) begin
                // Only data completions with a fetch waiting count toward starvation.
                if (iREN) begin
                    if (r_starve != STARVE_MAX)
                        r_starve <= r_starve + 1'b1;
                end else begin
                    r_starve <= '0;
                end
            end else if (w_i_done) begin
                r_starve <= '0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_d_req && !(iREN && (r_starve == STARVE_MAX)))
                    w_next_state = S_DGNT;
                else if (iREN)
                    w_next_state = S_IGNT;
            end
            S_DGNT: begin
                if (!w_d_req)                   w_next_state = S_IDLE;
                else if (ramstate == RS_ERROR)  w_next_state = S_BACKOFF;
                else if (ramstate == RS_ACCESS) w_next_state = S_IDLE;
            end
            S_IGNT: begin
                if (!iREN)                      w_next_state = S_IDLE;
                else if (ramstate == RS_ERROR)  w_next_state = S_BACKOFF;
                else if (ramstate == RS_ACCESS) w_next_state = S_IDLE;
            end
            S_BACKOFF: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Output logic. RAM enables follow the live request, so a dropped
    // request releases the RAM in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (r_state)
            S_DGNT: begin
                if (w_d_req) begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    dwait    = ~w_d_done;
                end
            end
            S_IGNT: begin
                if (iREN) begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    iwait   = ~w_i_done;
                end
            end
            default: ;
        endcase
    end

`ifdef MEM_ARBITER_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            igrant_cnt <= '0;
            dgrant_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            if (w_i_done) igrant_cnt <= igrant_cnt + 32'd1;
            if (w_d_done) dgrant_cnt <= dgrant_cnt + 32'd1;
            if (w_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. The RAM status is driven by hand in each
// step; inputs change 1 time unit after the rising edge and the combinational
// outputs are sampled 1 unit later, well away from the next edge.
module tb_mem_arbiter;

  localparam int W = 32;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic         CLK;
  logic         nRST;
  logic         iREN;
  logic [W-1:0] iaddr;
  logic         dREN;
  logic         dWEN;
  logic [W-1:0] daddr;
  logic [W-1:0] dstore;
  logic         iwait;
  logic         dwait;
  logic [W-1:0] iload;
  logic [W-1:0] dload;
  logic         ramREN;
  logic         ramWEN;
  logic [W-1:0] ramaddr;
  logic [W-1:0] ramstore;
  logic [W-1:0] ramload;
  logic [1:0]   ramstate;
`ifdef MEM_ARBITER_STATS_EN
  logic [31:0]  igrant_cnt;
  logic [31:0]  dgrant_cnt;
  logic [15:0]  err_cnt;
`endif

  int vectors;
  int miscompares;

  mem_arbiter #(.STARVE_LIMIT(4), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt), .err_cnt(err_cnt)
`endif
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; iaddr = '0;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
  endtask

  initial begin
    logic seq [$];
    logic exp_seq [10];
    vectors = 0;
    miscompares = 0;
    nRST = 1'b0;
    idle_inputs();

    // Reset state
    tick(); tick();
    chk("rst_iwait", W'(iwait), 1);
    chk("rst_dwait", W'(dwait), 1);
    chk("rst_ramREN", W'(ramREN), 0);
    chk("rst_ramWEN", W'(ramWEN), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    nRST = 1'b1;
    tick();

    // Single fetch, ACCESS two cycles after ramREN
    iREN = 1'b1; iaddr = 32'h100; ramstate = BUSY; settle();
    chk("f_idle_noren", W'(ramREN), 0);
    tick();
    chk("f_ramREN", W'(ramREN), 1);
    chk("f_ramaddr", ramaddr, 32'h100);
    chk("f_iwait_busy0", W'(iwait), 1);
    tick();
    chk("f_iwait_busy1", W'(iwait), 1);
    tick();
    ramstate = ACCESS; ramload = 32'h8C220004; settle();
    chk("f_iwait_pulse", W'(iwait), 0);
    chk("f_iload", iload, 32'h8C220004);
    chk("f_dwait", W'(dwait), 1);
    tick();
    idle_inputs(); settle();
    chk("f_iwait_after", W'(iwait), 1);
    chk("f_ramREN_after", W'(ramREN), 0);

    // Concurrent requests: data first, then fetch
    iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h2000; ramstate = FREE;
    tick();
    chk("c_d_ramaddr", ramaddr, 32'h2000);
    chk("c_d_ramREN", W'(ramREN), 1);
    ramstate = ACCESS; ramload = 32'h55; settle();
    chk("c_dwait_pulse", W'(dwait), 0);
    chk("c_dload", dload, 32'h55);
    chk("c_iwait_held", W'(iwait), 1);
    tick();
    dREN = 1'b0; daddr = '0; ramstate = FREE; settle();
    chk("c_dwait_after", W'(dwait), 1);
    tick();
    chk("c_i_ramaddr", ramaddr, 32'h300);
    chk("c_i_ramREN", W'(ramREN), 1);
    ramstate = ACCESS; ramload = 32'h77; settle();
    chk("c_iwait_pulse", W'(iwait), 0);
    chk("c_iload", iload, 32'h77);
    tick();
    idle_inputs();
    tick();

    // Starvation: fetch held, data back to back, RAM always ready
    exp_seq = '{0,0,0,0,1,0,0,0,0,1};
    iREN = 1'b1; iaddr = 32'h400; dREN = 1'b1; daddr = 32'h3000;
    ramstate = ACCESS; ramload = 32'hABCD; settle();
    for (int c = 0; c < 20; c++) begin
      vectors++;
      assert (!(iwait == 1'b0 && dwait == 1'b0)) else begin
        miscompares++;
        $error("FAIL s_both_low: cycle %0d iwait %0b dwait %0b expected not both 0", c, iwait, dwait);
      end
      if (!dwait) seq.push_back(1'b0);
      if (!iwait) seq.push_back(1'b1);
      tick();
    end
    chk("s_count", W'(seq.size()), 10);
    for (int k = 0; k < 10; k++) begin
      if (k < seq.size())
        chk($sformatf("s_order%0d", k), W'(seq[k]), W'(exp_seq[k]));
    end
    idle_inputs();
    tick();

    // Write precedence
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h40; dstore = 32'hDEADBEEF; ramstate = BUSY;
    tick();
    chk("w_ramWEN", W'(ramWEN), 1);
    chk("w_ramREN", W'(ramREN), 0);
    chk("w_ramstore", ramstore, 32'hDEADBEEF);
    chk("w_ramaddr", ramaddr, 32'h40);
    chk("w_dwait_busy", W'(dwait), 1);
    ramstate = ACCESS; settle();
    chk("w_dwait_pulse", W'(dwait), 0);
    tick();
    idle_inputs(); settle();
    chk("w_dwait_after", W'(dwait), 1);
    chk("w_ramWEN_after", W'(ramWEN), 0);

    // Error retry
    dREN = 1'b1; daddr = 32'h80; ramstate = BUSY;
    tick();
    chk("e_ramREN", W'(ramREN), 1);
    ramstate = ERROR; settle();
    chk("e_dwait_err", W'(dwait), 1);
    tick();
    ramstate = FREE; settle();
    chk("e_backoff_ren", W'(ramREN), 0);
    chk("e_backoff_wen", W'(ramWEN), 0);
    chk("e_backoff_dwait", W'(dwait), 1);
    tick();
    chk("e_idle_ren", W'(ramREN), 0);
    tick();
    chk("e_retry_ren", W'(ramREN), 1);
    chk("e_retry_addr", ramaddr, 32'h80);
    ramstate = ACCESS; ramload = 32'h1234; settle();
    chk("e_dwait_pulse", W'(dwait), 0);
    chk("e_dload", dload, 32'h1234);
    tick();
    idle_inputs();
    tick();

`ifdef MEM_ARBITER_STATS_EN
    chk("st_igrant", igrant_cnt, 4);
    chk("st_dgrant", dgrant_cnt, 11);
    chk("st_err", W'(err_cnt), 1);
`endif

    // Abort: drop dREN mid-BUSY
    dREN = 1'b1; daddr = 32'hA0; ramstate = BUSY;
    tick();
    chk("a_ramREN", W'(ramREN), 1);
    dREN = 1'b0; settle();
    chk("a_ramREN_drop", W'(ramREN), 0);
    chk("a_dwait_drop", W'(dwait), 1);
    tick();
    chk("a_dwait_next", W'(dwait), 1);
    chk("a_ramREN_next", W'(ramREN), 0);

    // Asynchronous reset mid-IGNT
    iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
    tick();
    chk("r_ramREN", W'(ramREN), 1);
    chk("r_ramaddr", ramaddr, 32'h500);
    nRST = 1'b0; settle();
    chk("r_async_ren", W'(ramREN), 0);
    chk("r_async_addr", ramaddr, 0);
    chk("r_async_iwait", W'(iwait), 1);
    chk("r_async_dwait", W'(dwait), 1);
    idle_inputs();
    tick();
    nRST = 1'b1;
    tick();
    chk("r_idle_ren", W'(ramREN), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
